// File: rtl/avl_burst_responder.sv
// Avalon-MM burst responder: on-chip RAM model of the DDR3 IP avl port with init/cal start-up.
// Optional build macro AVL_BACKPRESSURE_EN adds LFSR-driven avl_ready throttling in IDLE/WRITE.
module avl_burst_responder #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 128,
  parameter int BE_W        = DATA_W / 8,
  parameter int SIZE_W      = 9,
  parameter int MEM_AW      = 12,
  parameter int RD_LATENCY  = 4,
  parameter int INIT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              avl_ready,
  input  logic              avl_burstbegin,
  input  logic [ADDR_W-1:0] avl_addr,
  input  logic [SIZE_W-1:0] avl_size,
  input  logic [DATA_W-1:0] avl_wdata,
  input  logic [BE_W-1:0]   avl_be,
  input  logic              avl_write_req,
  input  logic              avl_read_req,
  output logic [DATA_W-1:0] avl_rdata,
  output logic              avl_rdata_valid,
  output logic              local_init_done,
  output logic              local_cal_success,
  output logic              local_cal_fail
);

  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int INIT_W    = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [INIT_W-1:0]   init_cnt;
  logic                init_done_q;
  logic [MEM_AW-1:0]   burst_addr;
  logic [SIZE_W-1:0]   burst_len;
  logic [SIZE_W-1:0]   beat_cnt;
  logic [SIZE_W-1:0]   req_len;
  logic                ready_gate;
  logic                wr_en;
  logic [MEM_AW-1:0]   wr_addr;
  logic                rd_issue;
  logic                init_expired;
  logic                last_beat;

  logic [DATA_W-1:0]   mem    [MEM_DEPTH];
  logic                pipe_v [RD_LATENCY];
  logic [DATA_W-1:0]   pipe_d [RD_LATENCY];

  // Burstbegin carries no information this model needs; high address bits alias.
  logic unused_inputs;
  assign unused_inputs = ^{avl_burstbegin, avl_addr[ADDR_W-1:MEM_AW]};

  assign req_len      = (avl_size == '0) ? SIZE_W'(1) : avl_size;
  assign init_expired = (init_cnt == INIT_W'(INIT_CYCLES));
  assign last_beat    = (beat_cnt == burst_len - SIZE_W'(1));

`ifdef AVL_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (state != S_INIT) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign ready_gate = (lfsr[1:0] != 2'b00);
`else
  assign ready_gate = 1'b1;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  if (init_expired) state_nx = S_IDLE;
      S_IDLE: begin
        if (ready_gate && avl_write_req) begin
          if (req_len != SIZE_W'(1)) state_nx = S_WRITE;
        end else if (ready_gate && avl_read_req) begin
          state_nx = S_READ;
        end
      end
      S_WRITE: if (ready_gate && avl_write_req && last_beat) state_nx = S_IDLE;
      S_READ:  if (last_beat) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // Output / control decode
  always_comb begin
    avl_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = burst_addr;
    rd_issue  = 1'b0;
    unique case (state)
      S_IDLE: begin
        avl_ready = ready_gate;
        wr_en     = ready_gate && avl_write_req;
        wr_addr   = avl_addr[MEM_AW-1:0];
      end
      S_WRITE: begin
        avl_ready = ready_gate;
        wr_en     = ready_gate && avl_write_req;
      end
      S_READ:  rd_issue = 1'b1;
      default: ;
    endcase
  end

  // Start-up counter and burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt    <= '0;
      init_done_q <= 1'b0;
      burst_addr  <= '0;
      burst_len   <= '0;
      beat_cnt    <= '0;
    end else begin
      if (state == S_INIT) begin
        if (init_expired) init_done_q <= 1'b1;
        else              init_cnt    <= init_cnt + INIT_W'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (ready_gate && avl_write_req) begin
            burst_addr <= avl_addr[MEM_AW-1:0] + MEM_AW'(1);
            burst_len  <= req_len;
            beat_cnt   <= SIZE_W'(1);
          end else if (ready_gate && avl_read_req) begin
            burst_addr <= avl_addr[MEM_AW-1:0];
            burst_len  <= req_len;
            beat_cnt   <= '0;
          end
        end
        S_WRITE: begin
          if (wr_en) begin
            burst_addr <= burst_addr + MEM_AW'(1);
            beat_cnt   <= beat_cnt + SIZE_W'(1);
          end
        end
        S_READ: begin
          burst_addr <= burst_addr + MEM_AW'(1);
          beat_cnt   <= beat_cnt + SIZE_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Byte-enabled RAM write
  // NOTE: the RAM array has no reset; contents survive rst_n so data written before a reset reads back after.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avl_be[b]) mem[wr_addr][8*b +: 8] <= avl_wdata[8*b +: 8];
      end
    end
  end

  // Read latency pipeline; stage 0 is the RAM read, the last stage drives the port.
  // Data stages only load on a valid beat, so avl_rdata holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_issue;
      if (rd_issue) pipe_d[0] <= mem[burst_addr];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign avl_rdata         = pipe_d[RD_LATENCY-1];
  assign avl_rdata_valid   = pipe_v[RD_LATENCY-1];
  assign local_init_done   = init_done_q;
  assign local_cal_success = init_done_q;
  assign local_cal_fail    = 1'b0;

endmodule
